// File: rtl/rtc_timekeeper.sv
// BCD real-time-clock core: divides the system clock to a 1 Hz tick, keeps hh:mm:ss in BCD,
// accepts time-set requests over valid/ready and raises a sticky alarm on match.
module rtc_timekeeper #(
  parameter int unsigned TICK_DIV = 40_000_000
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        run_en,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic        set_ready,
  output logic        set_err,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_clr,
  output logic        alarm_irq,
  output logic        tick_1hz,
  output logic [23:0] time_bcd,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [23:0]   time_q, time_d;
  logic [23:0]   set_q, set_d;
  logic          pend_q, pend_d;
  logic          set_ready_q, set_ready_d;
  logic          set_err_q, set_err_d;
  logic          alarm_q, alarm_d;
  logic [15:0]   oeb_q;
  logic          accept;
  logic          upd;
  logic          load_ok;

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (t[23:16] == 8'h23) r[23:16] = 8'h00;
            else if (t[19:16] != 4'd9) r[19:16] = t[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              r[23:20] = t[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [23:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
           (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
           (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23);
  endfunction

  assign accept = set_valid & set_ready_q;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    time_d    = time_q;
    set_d     = set_q;
    pend_d    = 1'b0;
    set_err_d = 1'b0;
    alarm_d   = alarm_q;
    upd       = 1'b0;
    load_ok   = 1'b0;

    unique case (state_q)
      STOP:    if (accept) state_d = LOAD; else if (run_en)  state_d = RUN;
      RUN:     if (accept) state_d = LOAD; else if (!run_en) state_d = STOP;
      LOAD:    state_d = run_en ? RUN : STOP;
      default: state_d = STOP;
    endcase

    if (state_q == RUN) begin
      if (presc_q == PMAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // A tick on the accept cycle is held until LOAD decides whether the load overrides it.
    if (accept) begin
      set_d  = set_time;
      pend_d = tick_q;
    end

    if (state_q == LOAD) begin
      if (bcd_valid(set_q)) begin
        time_d  = set_q;
        presc_d = '0;
        load_ok = 1'b1;
      end else begin
        set_err_d = 1'b1;
        if (tick_q | pend_q) begin
          time_d = bcd_inc(time_q);
          upd    = 1'b1;
        end
      end
    end else if (tick_q && !accept) begin
      time_d = bcd_inc(time_q);
      upd    = 1'b1;
    end

    if ((upd | load_ok) && alarm_en && (time_d == alarm_time)) alarm_d = 1'b1;
    else if (alarm_clr) alarm_d = 1'b0;

    set_ready_d = (state_d != LOAD);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= STOP;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      time_q      <= '0;
      set_q       <= '0;
      pend_q      <= 1'b0;
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_q     <= 1'b0;
      oeb_q       <= 16'hFFFF;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      time_q      <= time_d;
      set_q       <= set_d;
      pend_q      <= pend_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      alarm_q     <= alarm_d;
      oeb_q       <= 16'h0000;
    end
  end

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign alarm_irq = alarm_q;
  assign tick_1hz  = tick_q;
  assign time_bcd  = time_q;
  assign io_out    = time_q[15:0];
  assign io_oeb    = oeb_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with a 4-cycle prescaler: counting, loads, alarm, freeze, reset.
module tb_rtc_timekeeper;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        run_en = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = '0;
  logic        set_ready;
  logic        set_err;
  logic [23:0] alarm_time = '0;
  logic        alarm_en = 1'b0;
  logic        alarm_clr = 1'b0;
  logic        alarm_irq;
  logic        tick_1hz;
  logic [23:0] time_bcd;
  logic [15:0] io_out;
  logic [15:0] io_oeb;

  rtc_timekeeper #(.TICK_DIV(4)) dut (
    .clock(clock), .resetb(resetb), .run_en(run_en),
    .set_valid(set_valid), .set_time(set_time), .set_ready(set_ready), .set_err(set_err),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_clr(alarm_clr), .alarm_irq(alarm_irq),
    .tick_1hz(tick_1hz), .time_bcd(time_bcd), .io_out(io_out), .io_oeb(io_oeb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] t;
    logic        err;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl[10];
  logic [24:0] expq[$];
  int          nvec = 0;
  int          nfail = 0;
  int          sod = 0;

  function automatic logic [23:0] sod2bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_1hz && n < 40);
    if (!tick_1hz) chk("tick_seen", {31'd0, tick_1hz}, 32'd1);
  endtask

  task automatic tick_and_check(input int exp_gap, input string nm);
    int n;
    logic [24:0] e;
    wait_tick(n);
    if (exp_gap > 0) chk({nm, "_gap"}, n, exp_gap);
    sod = (sod + 1) % 86400;
    expq.push_back({1'b0, sod2bcd(sod)});
    step();
    e = expq.pop_front();
    chk(nm, time_bcd, e[23:0]);
    chk({nm, "_io"}, io_out, e[15:0]);
    chk({nm, "_pulse"}, tick_1hz, 0);
  endtask

  task automatic do_set(input logic [23:0] t, input logic err, input logic [23:0] exp_t);
    int n;
    logic [24:0] e;
    n = 0;
    while (!set_ready && n < 20) begin
      step();
      n++;
    end
    if (!set_ready) chk("set_ready_wait", {31'd0, set_ready}, 32'd1);
    set_valid = 1'b1;
    set_time  = t;
    expq.push_back({err, exp_t});
    step();
    set_valid = 1'b0;
    chk("set_ready_load", set_ready, 0);
    step();
    e = expq.pop_front();
    chk("set_err", set_err, e[24]);
    chk("set_time", time_bcd, e[23:0]);
    chk("set_ready_back", set_ready, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_time"}, time_bcd, 0);
    chk({nm, "_io"}, io_out, 0);
    chk({nm, "_tick"}, tick_1hz, 0);
    chk({nm, "_ready"}, set_ready, 0);
    chk({nm, "_err"}, set_err, 0);
    chk({nm, "_irq"}, alarm_irq, 0);
    chk({nm, "_oeb"}, io_oeb, 16'hFFFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int tk;
    tbl[0] = '{24'h123456, 1'b0, 24'h123456};
    tbl[1] = '{24'h246000, 1'b1, 24'h123456};
    tbl[2] = '{24'h12345A, 1'b1, 24'h123456};
    tbl[3] = '{24'h126000, 1'b1, 24'h123456};
    tbl[4] = '{24'h000060, 1'b1, 24'h123456};
    tbl[5] = '{24'h235959, 1'b0, 24'h235959};
    tbl[6] = '{24'h1A0000, 1'b1, 24'h235959};
    tbl[7] = '{24'h240000, 1'b1, 24'h235959};
    tbl[8] = '{24'h000000, 1'b0, 24'h000000};
    tbl[9] = '{24'h095909, 1'b0, 24'h095909};

    #1 resetb = 1'b0;
    #2 chk_reset_vals("reset");
    step();
    step();
    resetb = 1'b0;
    resetb = 1'b1;
    run_en = 1'b1;
    step();
    chk("ready_after_reset", set_ready, 1);
    chk("oeb_after_reset", io_oeb, 0);

    tick_and_check(0, "count");
    for (int i = 0; i < 11; i++) tick_and_check(3, "count");

    sod = 86398;
    do_set(24'h235958, 1'b0, 24'h235958);
    tick_and_check(4, "wrap_a");
    tick_and_check(3, "wrap_b");

    wait_tick(n);
    sod = 43200;
    do_set(24'h120000, 1'b0, 24'h120000);
    tick_and_check(4, "tick_on_set");

    wait_tick(n);
    do_set(24'h990000, 1'b1, sod2bcd(sod + 1));
    sod++;
    tick_and_check(0, "after_bad_on_tick");

    run_en = 1'b0;
    tk = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_1hz) tk++;
    end
    chk("freeze_ticks", tk, 0);
    chk("freeze_time", time_bcd, sod2bcd(sod));
    run_en = 1'b1;
    tick_and_check(3, "resume");

    run_en = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      do_set(tbl[i].t, tbl[i].err, tbl[i].exp);
      step();
      chk("tbl_err_pulse", set_err, 0);
      chk("tbl_time_hold", time_bcd, tbl[i].exp);
      chk("tbl_io", io_out, tbl[i].exp[15:0]);
    end

    run_en     = 1'b1;
    alarm_time = 24'h000003;
    alarm_en   = 1'b1;
    sod = 0;
    do_set(24'h000000, 1'b0, 24'h000000);
    chk("alarm_idle", alarm_irq, 0);
    tick_and_check(4, "alarm_t1");
    tick_and_check(3, "alarm_t2");
    chk("alarm_before", alarm_irq, 0);
    tick_and_check(3, "alarm_t3");
    chk("alarm_rise", alarm_irq, 1);
    tick_and_check(3, "alarm_t4");
    chk("alarm_hold", alarm_irq, 1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("alarm_clr", alarm_irq, 0);

    alarm_en = 1'b0;
    sod = 2;
    do_set(24'h000002, 1'b0, 24'h000002);
    tick_and_check(4, "alarm_dis_t3");
    chk("alarm_blocked", alarm_irq, 0);

    alarm_en  = 1'b1;
    alarm_clr = 1'b1;
    sod = 2;
    do_set(24'h000002, 1'b0, 24'h000002);
    tick_and_check(4, "alarm_win_t3");
    chk("alarm_set_wins", alarm_irq, 1);
    step();
    alarm_clr = 1'b0;
    chk("alarm_clr_again", alarm_irq, 0);
    do_set(24'h000003, 1'b0, 24'h000003);
    chk("alarm_on_load", alarm_irq, 1);

    set_valid = 1'b1;
    set_time  = 24'h111111;
    step();
    set_valid = 1'b0;
    chk("midload_ready", set_ready, 0);
    #2 resetb = 1'b0;
    #1 chk_reset_vals("midload_reset");
    step();
    step();
    resetb = 1'b1;
    run_en = 1'b0;
    step();
    chk("post_reset_time", time_bcd, 0);
    chk("post_reset_ready", set_ready, 1);
    chk("post_reset_oeb", io_oeb, 0);
    step();
    chk("post_reset_lost", time_bcd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
